// File: rtl/router_pkg.sv
// Shared router definitions: flit width, flit-type encoding in the top two bits, framing states.
// Pure declarations; no latency or flow-control behaviour of its own.
package router_pkg;

  localparam int FLIT_SIZE     = 32;
  localparam int FLIT_TYPE_MSB = FLIT_SIZE - 1;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    HEAD   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11
  } flit_type_t;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } frame_state_t;

  function automatic flit_type_t flit_type(input logic [FLIT_SIZE-1:0] flit);
    return flit_type_t'(flit[FLIT_TYPE_MSB -: 2]);
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// First-word fall-through FIFO on registered storage; head is visible the cycle after the write edge.
// A push into a full FIFO is taken only when a pop happens on the same edge; otherwise it is ignored.
module flit_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             push_acc, pop_acc;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == (AW+1)'(DEPTH));
  assign count_o  = count_q;
  assign pop_acc  = pop_i && !empty_o;
  // When full, the slot being written is the one being popped on the same edge.
  assign push_acc = push_i && (!full_o || pop_acc);
  assign pop_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_acc)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/flit_ejection_port.sv
// Router-to-PE ejection endpoint: on/off input, FWFT buffer, framing check, delivered-packet count.
// One-cycle fill latency; on/off hysteresis lags occupancy by a cycle; a full FIFO drops unless popped.
module flit_ejection_port
  import router_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int OFF_THRESH = DEPTH - 2,
  parameter int ON_THRESH  = DEPTH / 2,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [FLIT_SIZE-1:0] i_flit,
  input  logic                 i_transmit_req,
  output logic                 o_on_off,
  output logic [FLIT_SIZE-1:0] o_flit,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [CNT_W-1:0]     o_pkt_count,
  output logic                 o_overflow,
  output logic                 o_proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OFF_CNT = (AW+1)'(OFF_THRESH);
  localparam logic [AW:0] ON_CNT  = (AW+1)'(ON_THRESH);

  logic              fifo_full, fifo_empty, pop;
  logic [AW:0]       occ;
  flit_type_t        in_type, out_type;
  frame_state_t      state_q, state_d;
  logic              frame_err;
  logic              on_off_q, on_off_d;
  logic              overflow_q, overflow_d;
  logic              proto_err_q, proto_err_d;
  logic [CNT_W-1:0]  pkt_q, pkt_d;

  flit_fifo #(.DEPTH(DEPTH), .WIDTH(FLIT_SIZE)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (i_transmit_req),
    .push_dat_i (i_flit),
    .pop_i      (pop),
    .pop_dat_o  (o_flit),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (occ)
  );

  assign o_valid  = !fifo_empty;
  assign pop      = o_valid && i_ready;
  assign in_type  = flit_type(i_flit);
  assign out_type = flit_type(o_flit);

  // Framing is checked on every offered flit, including ones dropped for overflow.
  always_comb begin
    state_d   = state_q;
    frame_err = 1'b0;
    if (i_transmit_req) begin
      case (state_q)
        IDLE: begin
          case (in_type)
            HEAD:    state_d = IN_PKT;
            SINGLE:  state_d = IDLE;
            default: frame_err = 1'b1;
          endcase
        end
        IN_PKT: begin
          case (in_type)
            BODY:    state_d = IN_PKT;
            TAIL:    state_d = IDLE;
            HEAD:    frame_err = 1'b1;
            SINGLE: begin
              frame_err = 1'b1;
              state_d   = IDLE;
            end
            default: state_d = IN_PKT;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    on_off_d    = on_off_q;
    if (occ >= OFF_CNT)     on_off_d = 1'b0;
    else if (occ <= ON_CNT) on_off_d = 1'b1;
    overflow_d  = overflow_q | (i_transmit_req && fifo_full && !pop);
    proto_err_d = proto_err_q | frame_err;
    pkt_d       = pkt_q;
    if (pop && (out_type == TAIL || out_type == SINGLE)) pkt_d = pkt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      on_off_q    <= 1'b1;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
      pkt_q       <= '0;
    end else begin
      state_q     <= state_d;
      on_off_q    <= on_off_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
      pkt_q       <= pkt_d;
    end
  end

  assign o_on_off    = on_off_q;
  assign o_overflow  = overflow_q;
  assign o_proto_err = proto_err_q;
  assign o_pkt_count = pkt_q;

endmodule

// File: tb/tb_flit_ejection_port.sv
// Bench for flit_ejection_port: queue-based reference model checked every cycle, plus literal checkpoints.
// Directed stimulus covers fill/overflow, drain hysteresis, framing errors, mid-packet reset, full push+pop.
module tb_flit_ejection_port;
  import router_pkg::*;

  localparam int DEPTH = 8;
  localparam int OFF_T = 6;
  localparam int ON_T  = 4;
  localparam int CNT_W = 16;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [FLIT_SIZE-1:0] i_flit = '0;
  logic                 i_transmit_req = 1'b0;
  logic                 i_ready = 1'b0;
  logic                 o_on_off, o_valid, o_overflow, o_proto_err;
  logic [FLIT_SIZE-1:0] o_flit;
  logic [CNT_W-1:0]     o_pkt_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [FLIT_SIZE-1:0] mq[$];
  logic                 m_on_off = 1'b1;
  logic [CNT_W-1:0]     m_pkt = '0;
  logic                 m_ovf = 1'b0, m_perr = 1'b0, m_in_pkt = 1'b0;
  logic                 cmp_en = 1'b0;

  always #5 clk = ~clk;

  flit_ejection_port #(.DEPTH(DEPTH), .OFF_THRESH(OFF_T), .ON_THRESH(ON_T), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_flit         (i_flit),
    .i_transmit_req (i_transmit_req),
    .o_on_off       (o_on_off),
    .o_flit         (o_flit),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_pkt_count    (o_pkt_count),
    .o_overflow     (o_overflow),
    .o_proto_err    (o_proto_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_on_off = 1'b1;
    m_pkt    = '0;
    m_ovf    = 1'b0;
    m_perr   = 1'b0;
    m_in_pkt = 1'b0;
  endfunction

  // Reference behaviour of one clock edge, using the inputs presented before it.
  task automatic model_edge();
    int         occ;
    logic       do_pop;
    logic [1:0] t, pt;
    occ    = mq.size();
    do_pop = (occ > 0) && i_ready;
    t      = i_flit[FLIT_SIZE-1 -: 2];
    if (occ >= OFF_T)     m_on_off = 1'b0;
    else if (occ <= ON_T) m_on_off = 1'b1;
    if (do_pop) begin
      pt = mq[0][FLIT_SIZE-1 -: 2];
      if (pt == 2'b10 || pt == 2'b11) m_pkt = m_pkt + 1'b1;
      void'(mq.pop_front());
    end
    if (i_transmit_req) begin
      if (occ < DEPTH || do_pop) mq.push_back(i_flit);
      else                       m_ovf = 1'b1;
      if (!m_in_pkt) begin
        if (t == 2'b01)      m_in_pkt = 1'b1;
        else if (t != 2'b11) m_perr = 1'b1;
      end else begin
        if (t == 2'b10) m_in_pkt = 1'b0;
        else if (t == 2'b01) m_perr = 1'b1;
        else if (t == 2'b11) begin
          m_perr   = 1'b1;
          m_in_pkt = 1'b0;
        end
      end
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [FLIT_SIZE-1:0] ef;
    if (cmp_en && reset_n) begin
      ef = (mq.size() != 0) ? mq[0] : '0;
      chk("m_valid",  32'(o_valid),     32'(mq.size() != 0));
      chk("m_flit",   o_flit,           ef);
      chk("m_on_off", 32'(o_on_off),    32'(m_on_off));
      chk("m_pkt",    32'(o_pkt_count), 32'(m_pkt));
      chk("m_ovf",    32'(o_overflow),  32'(m_ovf));
      chk("m_perr",   32'(o_proto_err), 32'(m_perr));
    end
  end

  task automatic tick(input logic [31:0] f, input logic req, input logic rdy);
    i_flit         = f;
    i_transmit_req = req;
    i_ready        = rdy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  initial begin : main
    int                   got;
    logic [FLIT_SIZE-1:0] last;

    #7;
    chk("rst_valid",  32'(o_valid),     32'd0);
    chk("rst_flit",   o_flit,           32'd0);
    chk("rst_on_off", 32'(o_on_off),    32'd1);
    chk("rst_pkt",    32'(o_pkt_count), 32'd0);
    chk("rst_ovf",    32'(o_overflow),  32'd0);
    chk("rst_perr",   32'(o_proto_err), 32'd0);
    #5;
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    tick(32'hC000_0001, 1'b1, 1'b1);
    chk("single_valid", 32'(o_valid), 32'd1);
    chk("single_flit",  o_flit,       32'hC000_0001);
    tick(32'h0, 1'b0, 1'b1);
    chk("single_pkt",    32'(o_pkt_count), 32'd1);
    chk("single_on_off", 32'(o_on_off),    32'd1);

    tick(32'h4000_0010, 1'b1, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      tick(32'h0000_0010 + 32'(i), 1'b1, 1'b0);
      if (i == 5) chk("fill6_on_off", 32'(o_on_off), 32'd1);
      if (i == 6) chk("fill7_on_off", 32'(o_on_off), 32'd0);
    end
    chk("full_ovf",  32'(o_overflow), 32'd0);
    chk("full_head", o_flit,          32'h4000_0010);
    tick(32'h0000_0020, 1'b1, 1'b0);
    chk("drop_ovf", 32'(o_overflow), 32'd1);

    for (int i = 0; i < 8; i++) begin
      tick(32'h0, 1'b0, 1'b1);
      if (i == 3) chk("drain4_on_off", 32'(o_on_off), 32'd0);
      if (i == 4) chk("drain5_on_off", 32'(o_on_off), 32'd1);
    end
    chk("drained_valid", 32'(o_valid), 32'd0);

    tick(32'h8000_0030, 1'b1, 1'b1);
    tick(32'h0, 1'b0, 1'b1);
    chk("tail_pkt",  32'(o_pkt_count), 32'd2);
    chk("tail_perr", 32'(o_proto_err), 32'd0);

    tick(32'h0000_0040, 1'b1, 1'b1);
    chk("idle_body_perr", 32'(o_proto_err), 32'd1);
    chk("idle_body_flit", o_flit,           32'h0000_0040);
    tick(32'h0, 1'b0, 1'b1);
    chk("idle_body_pkt",  32'(o_pkt_count), 32'd2);

    tick(32'h4000_0050, 1'b1, 1'b0);
    tick(32'h0000_0051, 1'b1, 1'b0);
    tick(32'h0000_0052, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("arst_valid",  32'(o_valid),     32'd0);
    chk("arst_on_off", 32'(o_on_off),    32'd1);
    chk("arst_pkt",    32'(o_pkt_count), 32'd0);
    chk("arst_ovf",    32'(o_overflow),  32'd0);
    chk("arst_perr",   32'(o_proto_err), 32'd0);
    model_reset();
    #1;
    reset_n = 1'b1;
    tick(32'h4000_0060, 1'b1, 1'b1);
    tick(32'h8000_0061, 1'b1, 1'b1);
    tick(32'h0, 1'b0, 1'b1);
    chk("post_rst_perr", 32'(o_proto_err), 32'd0);
    chk("post_rst_pkt",  32'(o_pkt_count), 32'd1);

    tick(32'h4000_0070, 1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) tick(32'h0000_0070 + 32'(i), 1'b1, 1'b0);
    tick(32'h8000_0077, 1'b1, 1'b0);
    tick(32'hC000_0078, 1'b1, 1'b1);
    chk("pushpop_ovf", 32'(o_overflow), 32'd0);
    got  = 0;
    last = '0;
    for (int i = 0; i < 12; i++) begin
      if (o_valid) begin
        got++;
        last = o_flit;
      end
      tick(32'h0, 1'b0, 1'b1);
    end
    chk("pushpop_occ",  32'(got),          32'd8);
    chk("pushpop_last", last,              32'hC000_0078);
    chk("pushpop_pkt",  32'(o_pkt_count),  32'd3);
    chk("pushpop_perr", 32'(o_proto_err),  32'd0);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flit_ejection_port.md
# flit_ejection_port

Receive-side endpoint for a router output port. It accepts flits under on/off flow control, buffers them in a small FIFO and presents them to the local consumer over a valid/ready interface. It also checks head/body/tail framing and counts delivered packets. It sits between a `Router` output port and the local processing element, as the counterpart of the traffic source that drives a router input.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥ 4.
- `OFF_THRESH`, DEPTH-2: occupancy at or above which `o_on_off` drops.
- `ON_THRESH`, DEPTH/2: occupancy at or below which `o_on_off` rises again; must be < OFF_THRESH.
- `CNT_W`, 16: width of packet counter.

Ports:
- `clk`, in, 1: single clock; all logic on posedge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `i_flit`, in, FLIT_SIZE: flit from router output.
- `i_transmit_req`, in, 1: flit valid; sampled every posedge.
- `o_on_off`, out, 1: 1 = sender may transmit, 0 = stop.
- `o_flit`, out, FLIT_SIZE: head-of-FIFO flit.
- `o_valid`, out, 1: `o_flit` valid.
- `i_ready`, in, 1: consumer pops when `o_valid && i_ready`.
- `o_pkt_count`, out, CNT_W: tails delivered to the consumer, wraps modulo 2^CNT_W.
- `o_overflow`, out, 1: sticky; a flit arrived while full and was dropped.
- `o_proto_err`, out, 1: sticky; framing violation seen on input.

## Operation
- Flit type is `i_flit[FLIT_SIZE-1 -: 2]`: 01 HEAD, 00 BODY, 10 TAIL, 11 SINGLE (head+tail).
- Push: when `i_transmit_req`=1 and FIFO not full, write the flit.
- Full + simultaneous pop: the push is accepted and occupancy is unchanged.
- Full, no pop: the flit is dropped, `o_overflow` is set, occupancy is unchanged.
- Pop: when `o_valid && i_ready`. If the popped flit is TAIL or SINGLE, `o_pkt_count` increments.
- Flow control is a hysteresis register.
  - Clear when occupancy ≥ OFF_THRESH.
  - Set when occupancy ≤ ON_THRESH.
  - Otherwise hold.
- Framing FSM on accepted input flits (dropped flits are still checked):
  - IDLE: HEAD → IN_PKT. SINGLE → IDLE. BODY or TAIL → error, stay in IDLE.
  - IN_PKT: BODY → IN_PKT. TAIL → IDLE. HEAD or SINGLE → error, go to IN_PKT on HEAD and IDLE on SINGLE.
  - Any error sets `o_proto_err`.
- Flits are delivered in arrival order with no modification. Errored flits are still buffered.
- `o_overflow` and `o_proto_err` clear only on reset.

## Timing
- Reset values:
  - `o_on_off`=1, `o_valid`=0, `o_flit`=0.
  - `o_pkt_count`=0, `o_overflow`=0, `o_proto_err`=0.
  - FIFO empty, FSM in IDLE.
- Reset asserted mid-packet discards all buffered flits. Outputs take their reset values asynchronously.
- Latency: a flit sampled at posedge N appears with `o_valid`=1 at N+1 when the FIFO was empty (first-word fall-through from registered storage).
- `o_on_off` is registered from post-update occupancy. An occupancy change at posedge N is reflected on `o_on_off` after posedge N+1.
- The sender may keep sending for up to 2 cycles after `o_on_off` falls. With the default thresholds this fits in the 2 spare entries, so no flit is lost while the sender honours `o_on_off`.
- Pointers wrap modulo DEPTH. Occupancy is tracked in a $clog2(DEPTH)+1-bit counter.
- `o_pkt_count` updates the cycle after the pop edge and is registered.

## Structure
- `router_pkg` holds `flit_type_t` (HEAD/BODY/TAIL/SINGLE) and the `FLIT_TYPE_MSB` constant, alongside the existing `FLIT_SIZE`.
- Sub-module: `flit_fifo` (parameterised DEPTH/WIDTH, FWFT, push/pop/full/empty/count).
- Flow control, FSM and counters live in the top module.

## Test plan
- Reset, then SINGLE 0xC0000001 at cycle 0 with `i_ready`=1:
  - `o_valid`=1 with that flit at cycle 1.
  - `o_pkt_count`=1 after the pop.
  - `o_on_off` stays 1.
- `i_ready`=0, stream HEAD + 7 BODY (DEPTH=8):
  - `o_on_off` falls after occupancy reaches 6.
  - 8 flits buffered, `o_overflow`=0.
  - A 9th flit sets `o_overflow`=1 and is not delivered.
- Drain from full with `i_ready`=1: `o_on_off` returns to 1 one cycle after occupancy reaches 4; flits come out in order.
- Send BODY while in IDLE: `o_proto_err`=1, flit still delivered, `o_pkt_count` unchanged.
- Full FIFO with simultaneous push and pop: occupancy stays 8, no overflow, the new flit appears last.
- Assert `reset_n`=0 mid-packet with 3 flits buffered:
  - Immediately `o_valid`=0, `o_on_off`=1, counters 0.
  - After release, HEAD/TAIL is accepted with no error.
